// File: rtl/fft_buffer_sched_pkg.sv
// Shared definitions for the FFT ping-pong input buffer scheduler:
// default FFT size, writer/reader state encodings and the bit-reverse helper.
package fft_buffer_sched_pkg;

    // log2 of the default FFT size (64 points)
    localparam int NPT_LOG2_DEF  = 6;
    // default width of the completed-symbol counter
    localparam int SYM_CNT_W_DEF = 8;
    // widest address the bit-reverse helper can handle
    localparam int BITREV_MAX_W  = 16;

    typedef enum logic {
        W_FILL  = 1'b0,
        W_STALL = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_READ = 2'd2
    } rd_state_t;

    // Reverse the low 'width' bits of 'val' (bit 0 becomes bit width-1).
    // Bits at or above 'width' come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bit_rev(input logic [BITREV_MAX_W-1:0] val,
                                                        input int                      width);
        logic [BITREV_MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            if (i < width) begin
                res[width-1-i] = val[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_rd_seq.sv
// Reader sequencer: waits for a full bank, waits for the FFT core to be
// ready, then streams 64 natural-order addresses from that bank and
// releases it. Also counts completed symbols.
module fft_rd_seq
    import fft_buffer_sched_pkg::*;
#(
    parameter int NPT_LOG2  = NPT_LOG2_DEF,
    parameter int SYM_CNT_W = SYM_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,      // active-high, asynchronous
    input  logic                 fft_ready,
    input  logic [1:0]           bank_full,  // full flags including a bank completing this cycle
    output logic                 rd_en,
    output logic                 rd_bank,
    output logic [NPT_LOG2-1:0]  rd_addr,
    output logic                 fft_start,
    output logic                 rd_done,    // last read of a symbol; releases rd_bank
    output logic [SYM_CNT_W-1:0] sym_cnt
);

    localparam logic [NPT_LOG2-1:0] LAST_ADDR = '1;

    rd_state_t state;

    // Reader FSM, read address counter, bank pointer and symbol counter.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= R_IDLE;
            rd_bank <= 1'b0;
            rd_addr <= '0;
            sym_cnt <= '0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    // fft_ready is only looked at here; a drop mid-burst is ignored
                    if (fft_ready) begin
                        state   <= R_READ;
                        rd_addr <= '0;
                    end
                end
                R_READ: begin
                    rd_addr <= rd_addr + 1'b1;
                    if (rd_addr == LAST_ADDR) begin
                        rd_bank <= ~rd_bank;
                        sym_cnt <= sym_cnt + 1'b1;
                        state   <= bank_full[~rd_bank] ? R_WAIT : R_IDLE;
                    end
                end
                default: begin
                    state <= R_IDLE;
                end
            endcase
        end
    end

    assign rd_en     = (state == R_READ);
    assign fft_start = rd_en && (rd_addr == '0);
    assign rd_done   = rd_en && (rd_addr == LAST_ADDR);

endmodule

// File: rtl/fft_buffer_sched.sv
// Ping-pong buffer scheduler between the CP-removal stage and a 64-point
// FFT core. The writer fills one bank while the reader drains the other;
// per-bank full flags arbitrate ownership. Samples arriving while both
// banks are full are dropped and flagged on the sticky overflow output.
// Build option: define BITREV_ADDR_EN to write samples at bit-reversed
// addresses (wr_cnt[0] as MSB); otherwise addresses are natural order.
module fft_buffer_sched
    import fft_buffer_sched_pkg::*;
#(
    parameter int SYM_CNT_W = SYM_CNT_W_DEF,
    parameter int NPT_LOG2  = NPT_LOG2_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,      // active-high, asynchronous
    input  logic                 sym_valid,
    input  logic                 fft_ready,
    output logic                 wr_en,
    output logic                 wr_bank,
    output logic [NPT_LOG2-1:0]  wr_addr,
    output logic                 rd_en,
    output logic                 rd_bank,
    output logic [NPT_LOG2-1:0]  rd_addr,
    output logic                 fft_start,
    output logic                 overflow,
    output logic [SYM_CNT_W-1:0] sym_cnt
);

    localparam logic [NPT_LOG2-1:0] LAST_CNT = '1;

    wr_state_t           w_state;
    logic [NPT_LOG2-1:0] wr_cnt;
    logic [1:0]          full_q;
    logic [1:0]          full_set;
    logic [1:0]          full_clr;
    logic [1:0]          full_view;
    logic                wr_done;
    logic                rd_done;

    // Accept a sample whenever filling; held low while reset is asserted
    assign wr_en   = (w_state == W_FILL) && sym_valid && !rst_n;
    assign wr_done = wr_en && (wr_cnt == LAST_CNT);

`ifdef BITREV_ADDR_EN
    assign wr_addr = NPT_LOG2'(bit_rev(16'(wr_cnt), NPT_LOG2));
`else
    assign wr_addr = wr_cnt;
`endif

    // Per-bank set/clear requests from the writer and the reader
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (wr_done) full_set[wr_bank] = 1'b1;
        if (rd_done) full_clr[rd_bank] = 1'b1;
    end

    // The reader sees a bank completing this cycle so it can leave R_IDLE immediately
    assign full_view = full_q | full_set;

    // Bank full flags; set and clear of different banks both land in the same cycle
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            full_q <= '0;
        end else begin
            full_q <= (full_q | full_set) & ~full_clr;
        end
    end

    // Writer FSM: fill the current bank, then either move on or stall
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            w_state  <= W_FILL;
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            case (w_state)
                W_FILL: begin
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST_CNT) begin
                            wr_bank <= ~wr_bank;
                            // next bank still owned by the reader and not freed this cycle
                            if (full_q[~wr_bank] && !full_clr[~wr_bank]) begin
                                w_state <= W_STALL;
                            end
                        end
                    end
                end
                W_STALL: begin
                    if (sym_valid) begin
                        overflow <= 1'b1;
                    end
                    if (!full_q[wr_bank] || full_clr[wr_bank]) begin
                        w_state <= W_FILL;
                    end
                end
                default: begin
                    w_state <= W_FILL;
                end
            endcase
        end
    end

    // Reader FSM and read address generation
    fft_rd_seq #(
        .NPT_LOG2  (NPT_LOG2),
        .SYM_CNT_W (SYM_CNT_W)
    ) u_rd_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .fft_ready (fft_ready),
        .bank_full (full_view),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .fft_start (fft_start),
        .rd_done   (rd_done),
        .sym_cnt   (sym_cnt)
    );

endmodule
